// File: rtl/cpu6_irq_pkg.sv
// Shared constants for the cpu6 interrupt controller: state encodings, cause codes, datapath width.
package cpu6_irq_pkg;

  localparam int CPU6_XLEN = 32;

  localparam logic [1:0] CPU6_IRQ_ST_IDLE    = 2'd0;
  localparam logic [1:0] CPU6_IRQ_ST_ARM     = 2'd1;
  localparam logic [1:0] CPU6_IRQ_ST_TAKE    = 2'd2;
  localparam logic [1:0] CPU6_IRQ_ST_HANDLER = 2'd3;

  localparam logic [3:0] CPU6_IRQ_CAUSE_MEI = 4'd11;
  localparam logic [3:0] CPU6_IRQ_CAUSE_MTI = 4'd7;

  typedef struct packed {
    logic mei;
    logic mti;
  } irq_req_t;

  // Fixed priority: external beats timer.
  function automatic logic [3:0] irq_pick_cause(input irq_req_t r);
    return r.mei ? CPU6_IRQ_CAUSE_MEI : CPU6_IRQ_CAUSE_MTI;
  endfunction

endpackage

// File: rtl/cpu6_irq_ctrl_sync.sv
// 2-flop level synchronizer for the external interrupt; only built when CPU6_IRQ_SYNC_EN is defined.
`ifdef CPU6_IRQ_SYNC_EN
module cpu6_irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_d, s1_q, s2_d, s2_q;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule
`endif

// File: rtl/cpu6_irq_ctrl.sv
// Interrupt arbitration and trap-entry sequencer for cpu6.
// Define CPU6_IRQ_SYNC_EN to pass ext_irq through a 2-flop synchronizer first.
module cpu6_irq_ctrl
  import cpu6_irq_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ext_irq,
  input  logic            tmr_irq,
  input  logic            csr_meie_r,
  input  logic            csr_mtie_r,
  input  logic            csr_mstatus_mie_r,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            mret_ena,
  output logic            irq_hold,
  output logic            irq_flush,
  output logic [XLEN-1:0] irq_redirect_pc,
  output logic            tmr_irq_r,
  output logic            ext_irq_r,
  output logic            excp_mepc_ena,
  output logic [XLEN-1:0] excp_mepc,
  output logic [3:0]      irq_cause,
  output logic            irq_busy
);

  logic ext_s;

`ifdef CPU6_IRQ_SYNC_EN
  cpu6_irq_sync #(.W(1)) u_sync (
    .clk (clk),
    .rst (reset),
    .d   (ext_irq),
    .q   (ext_s)
  );
`else
  assign ext_s = ext_irq;
`endif

  irq_req_t  pend;
  logic      req;

  always_comb begin
    pend.mei = ext_s & csr_meie_r;
    pend.mti = tmr_irq & csr_mtie_r;
    req      = (pend.mei | pend.mti) & csr_mstatus_mie_r;
  end

  logic [1:0]      state_d, state_q;
  logic [XLEN-1:0] mepc_d, mepc_q;
  logic [XLEN-1:0] vec_d, vec_q;
  logic [3:0]      cause_d, cause_q;

  // Cause, mepc and vector are all frozen on the ARM->TAKE edge so that
  // TAKE outputs come purely from registers.
  always_comb begin
    state_d = state_q;
    mepc_d  = mepc_q;
    vec_d   = vec_q;
    cause_d = cause_q;
    case (state_q)
      CPU6_IRQ_ST_IDLE: if (req) state_d = CPU6_IRQ_ST_ARM;
      CPU6_IRQ_ST_ARM: begin
        if (!req) begin
          state_d = CPU6_IRQ_ST_IDLE;
        end else if (ex_valid) begin
          state_d = CPU6_IRQ_ST_TAKE;
          mepc_d  = ex_pc;
          cause_d = irq_pick_cause(pend);
          vec_d   = csr_mtvec & {{(XLEN-2){1'b1}}, 2'b00};
        end
      end
      CPU6_IRQ_ST_TAKE:    state_d = CPU6_IRQ_ST_HANDLER;
      CPU6_IRQ_ST_HANDLER: if (mret_ena) state_d = CPU6_IRQ_ST_IDLE;
      default:             state_d = CPU6_IRQ_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CPU6_IRQ_ST_IDLE;
      mepc_q  <= '0;
      vec_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      mepc_q  <= mepc_d;
      vec_q   <= vec_d;
      cause_q <= cause_d;
    end
  end

  logic in_take;
  assign in_take = (state_q == CPU6_IRQ_ST_TAKE);

  assign irq_hold        = (state_q == CPU6_IRQ_ST_ARM) | in_take;
  assign irq_flush       = in_take;
  assign irq_redirect_pc = in_take ? vec_q : '0;
  assign excp_mepc_ena   = in_take;
  assign excp_mepc       = mepc_q;
  assign ext_irq_r       = in_take & (cause_q == CPU6_IRQ_CAUSE_MEI);
  assign tmr_irq_r       = in_take & (cause_q == CPU6_IRQ_CAUSE_MTI);
  assign irq_cause       = cause_q;
  assign irq_busy        = (state_q == CPU6_IRQ_ST_HANDLER);

endmodule
